mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter sharing one memory/peripheral bus (DMEM, UART, timer decode behind it) between NUM_MASTERS requesters (core load/store ports, instruction fetch, or multiple cores). Each master runs a blocking request/acknowledge transaction. The arbiter latches the winning request, drives it to the slave until the slave acknowledges, and returns read data with a one-cycle ack to the winner. A watchdog counter aborts transactions the slave never acknowledges.

## Interface
- NUM_MASTERS, 2: number of requesters (2..8).
- TIMEOUT, 255: maximum BUSY cycles before abort (1..65535).
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master request; held high until its m_ack.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_addr  in  32*NUM_MASTERS  per-master byte address; master i in bits [32i+31:32i].
- m_wdata  in  32*NUM_MASTERS  per-master write data.
- m_be  in  4*NUM_MASTERS  per-master byte enables.
- m_ack  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- m_err  out  1  high with m_ack when the transaction timed out.
- m_rdata  out  32  read data, valid while m_ack is nonzero; broadcast to all masters.
- grant_id  out  3  index of current/last granted master.
- busy  out  1  high in BUSY and RESP.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_be  out  4  slave byte enables.
- s_ack  in  1  slave completion; s_rdata valid in the same cycle.
- s_rdata  in  32  slave read data.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any m_req is high, select a winner by round-robin. The search starts at last_grant+1, wraps modulo NUM_MASTERS, and takes the first requester found.
  - Latch the winner's we/addr/wdata/be and its index into grant_id.
  - Clear the watchdog and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - s_req=1; s_we/s_addr/s_wdata/s_be are driven from the latched registers only and are never combinational from the m_* inputs.
  - On s_ack: register s_rdata into m_rdata, clear m_err, go to RESP.
  - Otherwise increment the watchdog. When it equals TIMEOUT-1 without s_ack: set m_rdata=32'hDEAD_BEEF, set m_err=1, go to RESP.
  - s_ack and timeout in the same cycle: s_ack wins, no error.
- RESP:
  - m_ack[grant_id]=1 and s_req=0.
  - Set last_grant=grant_id and go to IDLE.
  - Requests are not sampled in RESP.
- Master protocol: the master drops m_req on the edge where it samples m_ack, unless it issues a new transaction. A req still high in the following IDLE cycle is a new transaction.
- Changes to m_* inputs of the granted master during BUSY have no effect.
- s_req, s_* fields, m_ack and m_err are zero outside the states listed above. m_rdata holds its last value.

## Timing
- Reset (asynchronous):
  - state=IDLE; last_grant=NUM_MASTERS-1, so master 0 wins first.
  - grant_id=0, watchdog=0, all outputs 0, m_rdata=0.
- Reset asserted mid-transaction: the transaction is dropped with no m_ack; s_req falls immediately on assertion.
- Latency:
  - m_req sampled in IDLE at cycle 0 -> s_req high in cycle 1.
  - s_ack sampled in cycle k -> m_ack in cycle k+1.
  - Minimum request-to-ack is 2 cycles (zero-wait slave). Each transaction occupies 3 cycles minimum.
- Timeout: with no s_ack, s_req is high for exactly TIMEOUT cycles, then m_ack+m_err follow in the next cycle.
- Fairness: under continuous requests from all masters, grants rotate 0,1,..,N-1,0. No master waits more than N-1 transactions.

## Structure
- Shared package bus_pkg holds the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), BUS_ERR_DATA=32'hDEAD_BEEF, and the address-map constants already used by core decode.
- Sub-module rr_picker: combinational; inputs req vector and last_grant; outputs valid and index. It is reused later for interrupt arbitration.
- Top level: state register, latch registers, watchdog counter, response registers.

## Test plan
- Single read: master 0 reads 0x0000_0100 and the slave acks in the same cycle with 0x1234_5678 -> s_req for 1 cycle, m_ack=2'b01 two cycles after the req, m_rdata=0x1234_5678, m_err=0.
- Simultaneous requests after reset: both masters request -> master 0 is granted first, then master 1. Keep both high continuously -> grants alternate 0,1,0,1.
- Write with wait states: master 1 writes 0xCAFE_F00D with be=4'b0011 to 0x4000_4004, slave acks after 5 cycles -> s_* fields stable for all 5 cycles, then m_ack=2'b10.
- Timeout: TIMEOUT=8, slave never acks -> s_req high exactly 8 cycles, then m_ack plus m_err=1 with m_rdata=0xDEAD_BEEF, then the arbiter returns to IDLE.
- Reset mid-BUSY: assert rst during cycle 3 of a wait-state transaction -> s_req drops without waiting for a clock, no m_ack is issued, and master 0 wins the first grant after reset.
- Input change during BUSY: the granted master changes m_addr after the grant -> s_addr keeps the latched address.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : shared bus state encoding, error data word and address map
// Revision: 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Address map shared with the core's load/store decode
    localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DMEM_SIZE  = 32'h0001_0000;
    localparam logic [31:0] UART_BASE  = 32'h4000_0000;
    localparam logic [31:0] TIMER_BASE = 32'h4000_4000;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational round-robin selector starting after last_grant
// Revision: 1.0
// ============================================================================
module rr_picker #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [2:0]             last_grant,
    output logic                   valid,
    output logic [2:0]             index
);

    logic       w_hi_valid;
    logic [2:0] w_hi_index;
    logic [2:0] w_lo_index;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_valid = 1'b0;
        w_hi_index = 3'd0;
        w_lo_index = 3'd0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_index = 3'(i);
                if (3'(i) > last_grant) begin
                    w_hi_valid = 1'b1;
                    w_hi_index = 3'(i);
                end
            end
        end
        valid = |req;
        index = w_hi_valid ? w_hi_index : w_lo_index;
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : round-robin arbiter of N masters onto one slave bus
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_be,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic                      m_err,
    output logic [31:0]               m_rdata,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      s_req,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_be,
    input  logic                      s_ack,
    input  logic [31:0]               s_rdata
);

    localparam logic [15:0]            c_wd_last    = 16'(TIMEOUT - 1);
    localparam logic [2:0]             c_last_reset = 3'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] c_ack_one    = NUM_MASTERS'(1);

    bus_state_t             r_state;
    logic [2:0]             r_last_grant;
    logic [2:0]             r_grant_id;
    logic [15:0]            r_wd;
    logic                   r_busy;
    logic                   r_s_req;
    logic                   r_s_we;
    logic [31:0]            r_s_addr;
    logic [31:0]            r_s_wdata;
    logic [3:0]             r_s_be;
    logic [NUM_MASTERS-1:0] r_m_ack;
    logic                   r_m_err;
    logic [31:0]            r_m_rdata;

    logic                   w_pick_valid;
    logic [2:0]             w_pick_index;
    logic                   w_sel_we;
    logic [31:0]            w_sel_addr;
    logic [31:0]            w_sel_wdata;
    logic [3:0]             w_sel_be;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req        (m_req),
        .last_grant (r_last_grant),
        .valid      (w_pick_valid),
        .index      (w_pick_index)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        w_sel_be    = 4'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (3'(i) == w_pick_index) begin
                w_sel_we    = m_we[i];
                w_sel_addr  = m_addr[32*i +: 32];
                w_sel_wdata = m_wdata[32*i +: 32];
                w_sel_be    = m_be[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= c_last_reset;
            r_grant_id   <= 3'd0;
            r_wd         <= 16'd0;
            r_busy       <= 1'b0;
            r_s_req      <= 1'b0;
            r_s_we       <= 1'b0;
            r_s_addr     <= 32'd0;
            r_s_wdata    <= 32'd0;
            r_s_be       <= 4'd0;
            r_m_ack      <= '0;
            r_m_err      <= 1'b0;
            r_m_rdata    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= BUSY;
                        r_grant_id <= w_pick_index;
                        r_wd       <= 16'd0;
                        r_busy     <= 1'b1;
                        r_s_req    <= 1'b1;
                        r_s_we     <= w_sel_we;
                        r_s_addr   <= w_sel_addr;
                        r_s_wdata  <= w_sel_wdata;
                        r_s_be     <= w_sel_be;
                    end
                end
                BUSY: begin
                    // s_ack takes priority over a watchdog expiry in the same cycle
                    if (s_ack || (r_wd == c_wd_last)) begin
                        r_state   <= RESP;
                        r_s_req   <= 1'b0;
                        r_s_we    <= 1'b0;
                        r_s_addr  <= 32'd0;
                        r_s_wdata <= 32'd0;
                        r_s_be    <= 4'd0;
                        r_m_ack   <= c_ack_one << r_grant_id;
                        r_m_err   <= !s_ack;
                        r_m_rdata <= s_ack ? s_rdata : BUS_ERR_DATA;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_last_grant <= r_grant_id;
                    r_busy       <= 1'b0;
                    r_m_ack      <= '0;
                    r_m_err      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_s_req <= 1'b0;
                    r_m_ack <= '0;
                    r_m_err <= 1'b0;
                end
            endcase
        end
    end

    assign m_ack    = r_m_ack;
    assign m_err    = r_m_err;
    assign m_rdata  = r_m_rdata;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign s_req    = r_s_req;
    assign s_we     = r_s_we;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_be     = r_s_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : randomized transaction bench with a round-robin model
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int NM = 2;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NM-1:0]       m_req;
    logic [NM-1:0]       m_we;
    logic [32*NM-1:0]    m_addr;
    logic [32*NM-1:0]    m_wdata;
    logic [4*NM-1:0]     m_be;
    logic [NM-1:0]       m_ack;
    logic                m_err;
    logic [31:0]         m_rdata;
    logic [2:0]          grant_id;
    logic                busy;
    logic                s_req;
    logic                s_we;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_be;
    logic                s_ack;
    logic [31:0]         s_rdata;

    int vectors     = 0;
    int miscompares = 0;

    // Master-side transaction state, one entry per master
    logic        req_m   [NM];
    logic        we_m    [NM];
    logic [31:0] addr_m  [NM];
    logic [31:0] wdata_m [NM];
    logic [3:0]  be_m    [NM];
    int          last_win  = NM - 1;
    logic [31:0] exp_rdata = 32'd0;

    mem_bus_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .grant_id (grant_id),
        .busy     (busy),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_be     (s_be),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < NM; i++) begin
            m_req[i]             = req_m[i];
            m_we[i]              = we_m[i];
            m_addr[32*i +: 32]   = addr_m[i];
            m_wdata[32*i +: 32]  = wdata_m[i];
            m_be[4*i +: 4]       = be_m[i];
        end
    endtask

    task automatic new_req(input int i);
        req_m[i]   = 1'b1;
        we_m[i]    = 1'($urandom_range(0, 1));
        addr_m[i]  = $urandom;
        wdata_m[i] = $urandom;
        be_m[i]    = 4'($urandom_range(0, 15));
    endtask

    // First pending requester after the previous winner, wrapping around
    function automatic int rr_winner();
        for (int k = 1; k <= NM; k++) begin
            if (req_m[(last_win + k) % NM]) return (last_win + k) % NM;
        end
        return -1;
    endfunction

    // Called at a falling edge while idle. d = BUSY cycle carrying s_ack; d > TO means no ack.
    task automatic run_txn(input int d, input logic [31:0] rd);
        int          w;
        int          n;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        check_val("idle_s_req", 32'(s_req), 32'd0);
        check_val("idle_busy",  32'(busy),  32'd0);
        check_val("idle_m_ack", 32'(m_ack), 32'd0);
        w = rr_winner();
        if (w < 0) begin
            @(posedge clk);
            @(negedge clk);
            return;
        end
        e_we = we_m[w]; e_addr = addr_m[w]; e_wdata = wdata_m[w]; e_be = be_m[w];
        n = (d <= TO) ? d : TO;
        @(posedge clk);
        @(negedge clk);
        // The granted master scribbles on its inputs; the slave side must not notice
        we_m[w] = ~we_m[w]; addr_m[w] = $urandom; wdata_m[w] = $urandom; be_m[w] = ~be_m[w];
        drive_masters();
        for (int j = 1; j <= n; j++) begin
            check_val("busy_s_req",    32'(s_req),    32'd1);
            check_val("busy_busy",     32'(busy),     32'd1);
            check_val("busy_grant_id", 32'(grant_id), 32'(w));
            check_val("busy_s_we",     32'(s_we),     32'(e_we));
            check_val("busy_s_addr",   s_addr,        e_addr);
            check_val("busy_s_wdata",  s_wdata,       e_wdata);
            check_val("busy_s_be",     32'(s_be),     32'(e_be));
            check_val("busy_m_ack",    32'(m_ack),    32'd0);
            if (j == d) begin
                s_ack   = 1'b1;
                s_rdata = rd;
            end
            @(posedge clk);
            @(negedge clk);
            s_ack   = 1'b0;
            s_rdata = $urandom;
        end
        exp_rdata = (d <= TO) ? rd : 32'hDEAD_BEEF;
        check_val("resp_s_req",    32'(s_req),    32'd0);
        check_val("resp_m_ack",    32'(m_ack),    32'd1 << w);
        check_val("resp_m_err",    32'(m_err),    (d > TO) ? 32'd1 : 32'd0);
        check_val("resp_m_rdata",  m_rdata,       exp_rdata);
        check_val("resp_grant_id", 32'(grant_id), 32'(w));
        last_win = w;
        req_m[w] = 1'b0;
        drive_masters();
        @(posedge clk);
        @(negedge clk);
        check_val("post_m_ack",   32'(m_ack), 32'd0);
        check_val("post_m_err",   32'(m_err), 32'd0);
        check_val("post_m_rdata", m_rdata,    exp_rdata);
    endtask

    function automatic int pick_delay(input int t);
        if (t % 7 == 0) return TO;
        if (t % 5 == 0) return TO + 1;
        return $urandom_range(1, TO + 2);
    endfunction

    initial begin
        s_ack = 1'b0;
        s_rdata = 32'd0;
        for (int i = 0; i < NM; i++) begin
            req_m[i] = 1'b0; we_m[i] = 1'b0; addr_m[i] = 32'd0; wdata_m[i] = 32'd0; be_m[i] = 4'd0;
        end
        drive_masters();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_s_req",    32'(s_req),    32'd0);
        check_val("rst_m_ack",    32'(m_ack),    32'd0);
        check_val("rst_m_err",    32'(m_err),    32'd0);
        check_val("rst_m_rdata",  m_rdata,       32'd0);
        check_val("rst_grant_id", 32'(grant_id), 32'd0);
        check_val("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;

        // Single zero-wait read from master 0
        req_m[0] = 1'b1; we_m[0] = 1'b0; addr_m[0] = 32'h0000_0100; wdata_m[0] = 32'd0; be_m[0] = 4'hF;
        drive_masters();
        run_txn(1, 32'h1234_5678);

        // Both request; master 1 write with wait states, then master 0 read
        req_m[0] = 1'b1; we_m[0] = 1'b0; addr_m[0] = 32'h0000_0200; wdata_m[0] = 32'd0; be_m[0] = 4'hF;
        req_m[1] = 1'b1; we_m[1] = 1'b1; addr_m[1] = 32'h4000_4004; wdata_m[1] = 32'hCAFE_F00D; be_m[1] = 4'b0011;
        drive_masters();
        run_txn(5, $urandom);
        run_txn(2, $urandom);

        // Timeout with no slave ack
        new_req(0);
        drive_masters();
        run_txn(TO + 1, 32'd0);

        // Continuous requests from all masters: grants must rotate
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NM; i++) if (!req_m[i]) new_req(i);
            drive_masters();
            run_txn($urandom_range(1, 3), $urandom);
        end

        // Randomized traffic
        for (int t = 1; t <= 200; t++) begin
            for (int i = 0; i < NM; i++) begin
                if (!req_m[i] && $urandom_range(0, 3) != 0) new_req(i);
            end
            drive_masters();
            run_txn(pick_delay(t), $urandom);
        end

        // Reset asserted in the third BUSY cycle of a long transaction
        for (int i = 0; i < NM; i++) if (!req_m[i]) new_req(i);
        drive_masters();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("mid_s_req_before", 32'(s_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_s_req_async", 32'(s_req), 32'd0);
        check_val("mid_busy_async",  32'(busy),  32'd0);
        @(negedge clk);
        check_val("mid_m_ack",    32'(m_ack),    32'd0);
        check_val("mid_m_rdata",  m_rdata,       32'd0);
        check_val("mid_grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        last_win  = NM - 1;
        exp_rdata = 32'd0;
        run_txn(1, $urandom);
        run_txn(3, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
`default_nettype wire
